// File: rtl/plotter_pkg.sv
// Shared types and constants for the stepper motion block.
//   mode_e          : drive mode as presented on cmd_mode
//   state_e         : move controller states
//   HALF_STEP_TABLE : coil pattern per half-step phase index, entry 0 in the LSBs
package plotter_pkg;

    typedef enum logic [1:0] {
        ModeWave    = 2'b00,
        ModeFull    = 2'b01,
        ModeHalf    = 2'b10,
        ModeFullAlt = 2'b11
    } mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Index 7 is written first so that HALF_STEP_TABLE[i] yields phase i.
    localparam logic [7:0][3:0] HALF_STEP_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

endpackage

// File: rtl/stepper_phase_seq.sv
// One axis of the stepper drive: phase index, remaining step count, signed position
// and coil lookup.
//   clk, resetn    : clock and synchronous active-low reset
//   load           : latch a new move (steps, mode)
//   step_en        : advance one step if any remain
//   mode           : drive mode, sampled on load
//   steps          : signed step count, sampled on load
//   coil_en        : drive coils when high, otherwise output zero
//   coil           : coil pattern
//   pos            : signed position in half-step units
//   remaining_zero : no steps left on this axis
module stepper_phase_seq
    import plotter_pkg::*;
#(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned POS_W  = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              step_en,
    input  mode_e             mode,
    input  logic [STEP_W-1:0] steps,
    input  logic              coil_en,
    output logic [3:0]        coil,
    output logic [POS_W-1:0]  pos,
    output logic              remaining_zero
);

    logic [2:0]        idx_q, idx_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic [2:0]        idx_delta;
    logic [POS_W-1:0]  pos_delta;

    always_comb begin
        idx_d     = idx_q;
        rem_d     = rem_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        half_d    = half_q;
        idx_delta = half_q ? 3'd1 : 3'd2;
        pos_delta = half_q ? POS_W'(1) : POS_W'(2);
        if (load) begin
            dir_d  = steps[STEP_W-1];
            // Negation in STEP_W bits: the most-negative count maps to 2^(STEP_W-1).
            rem_d  = steps[STEP_W-1] ? (~steps + STEP_W'(1)) : steps;
            half_d = (mode == ModeHalf);
            // Wave uses single-coil (even) phases, full uses two-coil (odd) phases.
            unique case (mode)
                ModeWave: idx_d[0] = 1'b0;
                ModeHalf: idx_d    = idx_q;
                default:  idx_d[0] = 1'b1;
            endcase
        end else if (step_en && (rem_q != '0)) begin
            idx_d = dir_q ? (idx_q - idx_delta) : (idx_q + idx_delta);
            pos_d = dir_q ? (pos_q - pos_delta) : (pos_q + pos_delta);
            rem_d = rem_q - STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_q  <= '0;
            rem_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            half_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            half_q <= half_d;
        end
    end

    assign coil           = coil_en ? HALF_STEP_TABLE[idx_q] : 4'b0000;
    assign pos            = pos_q;
    assign remaining_zero = (rem_q == '0);

endmodule

// File: rtl/stepper_move_ctrl.sv
// Multi-axis 4-coil stepper move controller. Accepts one move command at a time,
// steps every axis with steps remaining once per step period, and pulses done when
// all axes finish or the move is aborted.
//   clk_100mhz, cpu_resetn : clock and synchronous active-low reset
//   cmd_valid / cmd_ready  : command handshake (ready only while idle)
//   cmd_steps              : per-axis signed step counts, axis 0 in the LSBs
//   cmd_mode               : 00 wave, 01 full, 10 half, 11 full
//   cmd_period             : clocks per step, clamped up to MIN_PERIOD
//   abort                  : end the running move
//   hold_en                : keep coils energised while idle
//   coil_out, pos_out      : per-axis coil drive and signed position
//   busy, done             : move running, one-cycle completion pulse
module stepper_move_ctrl #(
    parameter int unsigned NUM_AXES   = 2,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned PERIOD_W   = 24,
    parameter int unsigned MIN_PERIOD = 100000,
    parameter int unsigned POS_W      = 20
) (
    input  logic                         clk_100mhz,
    input  logic                         cpu_resetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [NUM_AXES*STEP_W-1:0]   cmd_steps,
    input  logic [1:0]                   cmd_mode,
    input  logic [PERIOD_W-1:0]          cmd_period,
    input  logic                         abort,
    input  logic                         hold_en,
    output logic [NUM_AXES*4-1:0]        coil_out,
    output logic [NUM_AXES*POS_W-1:0]    pos_out,
    output logic                         busy,
    output logic                         done
);

    import plotter_pkg::*;

    localparam logic [PERIOD_W-1:0] MinPeriodW = PERIOD_W'(MIN_PERIOD);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] period_eff;
    logic                done_q, done_d;
    logic                load;
    logic                tick;
    logic                step_en;
    logic                coil_en;
    logic [NUM_AXES-1:0] remaining_zero;
    logic                all_zero;

    assign period_eff = (cmd_period < MinPeriodW) ? MinPeriodW : cmd_period;
    assign tick       = (state_q == StRun) && (cnt_q == period_q - PERIOD_W'(1));
    assign all_zero   = &remaining_zero;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step_en  = 1'b0;
        if (state_q == StIdle) begin
            cnt_d = '0;
            if (cmd_valid) begin
                load     = 1'b1;
                period_d = period_eff;
                state_d  = StRun;
            end
        end else begin
            // Abort wins over a coincident tick: no step is taken on the abort edge.
            if (abort || all_zero) begin
                state_d = StIdle;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                step_en = tick;
                cnt_d   = tick ? '0 : (cnt_q + PERIOD_W'(1));
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!cpu_resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= MinPeriodW;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            done_q   <= done_d;
        end
    end

    assign coil_en = (state_q == StRun) || hold_en;

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        stepper_phase_seq #(
            .STEP_W (STEP_W),
            .POS_W  (POS_W)
        ) u_seq (
            .clk            (clk_100mhz),
            .resetn         (cpu_resetn),
            .load           (load),
            .step_en        (step_en),
            .mode           (mode_e'(cmd_mode)),
            .steps          (cmd_steps[a*STEP_W +: STEP_W]),
            .coil_en        (coil_en),
            .coil           (coil_out[a*4 +: 4]),
            .pos            (pos_out[a*POS_W +: POS_W]),
            .remaining_zero (remaining_zero[a])
        );
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign done      = done_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
`timescale 1ns/1ps
module tb_stepper_move_ctrl;

    localparam int NA = 2;
    localparam int SW = 16;
    localparam int PW = 24;
    localparam int QW = 20;

    logic            clk_100mhz = 1'b0;
    logic            cpu_resetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [NA*SW-1:0] cmd_steps;
    logic [1:0]      cmd_mode;
    logic [PW-1:0]   cmd_period;
    logic            abort;
    logic            hold_en;
    logic [NA*4-1:0] coil_out;
    logic [NA*QW-1:0] pos_out;
    logic            busy;
    logic            done;

    stepper_move_ctrl #(
        .NUM_AXES   (NA),
        .STEP_W     (SW),
        .PERIOD_W   (PW),
        .MIN_PERIOD (4),
        .POS_W      (QW)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .cpu_resetn (cpu_resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_mode   (cmd_mode),
        .cmd_period (cmd_period),
        .abort      (abort),
        .hold_en    (hold_en),
        .coil_out   (coil_out),
        .pos_out    (pos_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        int          cyc;
        logic [7:0]  coil;
        logic [39:0] pos;
        logic        done;
        logic        busy;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  model_idx[NA];
    int  model_pos[NA];

    function automatic logic [3:0] coil_of(input int idx);
        case (idx & 7)
            0: coil_of = 4'b1000;
            1: coil_of = 4'b1100;
            2: coil_of = 4'b0100;
            3: coil_of = 4'b0110;
            4: coil_of = 4'b0010;
            5: coil_of = 4'b0011;
            6: coil_of = 4'b0001;
            default: coil_of = 4'b1001;
        endcase
    endfunction

    function automatic logic [7:0] model_coil(input logic en);
        model_coil = en ? {coil_of(model_idx[1]), coil_of(model_idx[0])} : 8'h00;
    endfunction

    function automatic logic [39:0] model_posv();
        logic [19:0] p0, p1;
        p0 = 20'(model_pos[0]);
        p1 = 20'(model_pos[1]);
        model_posv = {p1, p0};
    endfunction

    task automatic push_ev(input int cyc, input logic [7:0] coil, input logic dn, input logic bz);
        ev_t e;
        e.cyc  = cyc;
        e.coil = coil;
        e.pos  = model_posv();
        e.done = dn;
        e.busy = bz;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_100mhz);
        cpu_resetn = 1'b0;
        cmd_valid  = 1'b0;
        abort      = 1'b0;
        @(posedge clk_100mhz);
        @(posedge clk_100mhz);
        #1;
        for (int a = 0; a < NA; a++) begin
            model_idx[a] = 0;
            model_pos[a] = 0;
        end
    endtask

    task automatic release_reset();
        @(negedge clk_100mhz);
        cpu_resetn = 1'b1;
    endtask

    // Build the expected trace into the scoreboard, issue the command, then walk the
    // cycles after the accepting edge comparing whatever the scoreboard holds.
    task automatic run_move(input string name, input logic [1:0] mode, input int s0, input int s1,
                            input int period, input int abort_at, input logic hold,
                            input logic poke);
        int s[NA];
        int mag[NA];
        int p, n, d, step, dn_cnt;
        ev_t e;
        s[0] = s0;
        s[1] = s1;
        p = (period < 4) ? 4 : period;
        step = (mode == 2'b10) ? 1 : 2;
        n = 0;
        for (int a = 0; a < NA; a++) begin
            mag[a] = (s[a] < 0) ? -s[a] : s[a];
            if (mag[a] > n) n = mag[a];
            if (mode == 2'b00) model_idx[a] = model_idx[a] & 6;
            else if (mode != 2'b10) model_idx[a] = model_idx[a] | 1;
        end
        push_ev(0, model_coil(1'b1), 1'b0, 1'b1);
        for (int k = 1; k <= n; k++) begin
            if (abort_at >= 0 && k * p > abort_at) break;
            for (int a = 0; a < NA; a++) begin
                if (k <= mag[a]) begin
                    model_idx[a] = (model_idx[a] + ((s[a] < 0) ? -step : step)) & 7;
                    model_pos[a] = model_pos[a] + ((s[a] < 0) ? -step : step);
                end
            end
            push_ev(k * p, model_coil(1'b1), 1'b0, 1'b1);
        end
        if (abort_at >= 0 && abort_at + 1 <= n * p) d = abort_at + 1;
        else d = n * p + 1;
        push_ev(d, model_coil(hold), 1'b1, 1'b0);

        @(negedge clk_100mhz);
        hold_en    = hold;
        cmd_mode   = mode;
        cmd_period = PW'(period);
        cmd_steps  = {SW'(s1), SW'(s0)};
        cmd_valid  = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, cmd_ready);
        end
        @(posedge clk_100mhz);
        #1;
        cmd_valid = 1'b0;
        dn_cnt = 0;
        for (int cyc = 0; cyc <= d + 1; cyc++) begin
            abort = (cyc == abort_at);
            if (poke && cyc == 2) begin
                cmd_valid = 1'b1;
                cmd_steps = {SW'(7), SW'(-7)};
            end else begin
                cmd_valid = 1'b0;
            end
            if (done === 1'b1) dn_cnt++;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                total++;
                if (coil_out !== e.coil) begin
                    bad++;
                    $display("FAIL %s coil@%0d: got %b want %b", name, cyc, coil_out, e.coil);
                end
                total++;
                if (pos_out !== e.pos) begin
                    bad++;
                    $display("FAIL %s pos@%0d: got %h want %h", name, cyc, pos_out, e.pos);
                end
                total++;
                if (done !== e.done) begin
                    bad++;
                    $display("FAIL %s done@%0d: got %b want %b", name, cyc, done, e.done);
                end
                total++;
                if (busy !== e.busy || cmd_ready !== ~e.busy) begin
                    bad++;
                    $display("FAIL %s busy/ready@%0d: got %b/%b want %b/%b", name, cyc, busy,
                             cmd_ready, e.busy, ~e.busy);
                end
            end
            @(posedge clk_100mhz);
            #1;
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        total++;
        if (dn_cnt != 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d want 1", name, dn_cnt);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s scoreboard_left: got %0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        hold_en = 1'b0;
        do_reset();
        total++;
        if (coil_out !== 8'h00) begin bad++; $display("FAIL reset coil: got %h want 00", coil_out); end
        total++;
        if (pos_out !== 40'h0) begin bad++; $display("FAIL reset pos: got %h want 0", pos_out); end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done);
        end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", cmd_ready); end
        hold_en = 1'b1;
        #1;
        total++;
        if (coil_out !== 8'h88) begin bad++; $display("FAIL reset hold coil: got %h want 88", coil_out); end
        release_reset();
    endtask

    task automatic test_half();
        run_move("half", 2'b10, 3, -2, 4, -1, 1'b1, 1'b0);
    endtask

    task automatic test_full_clamp();
        do_reset();
        release_reset();
        run_move("full_clamp", 2'b01, 1, 0, 2, -1, 1'b1, 1'b0);
    endtask

    task automatic test_zero();
        run_move("zero", 2'b10, 0, 0, 4, -1, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        run_move("abort", 2'b01, 100, 100, 4, 10, 1'b1, 1'b1);
    endtask

    task automatic test_hold_resume();
        run_move("hold_off", 2'b10, 1, 1, 4, -1, 1'b0, 1'b0);
        run_move("resume", 2'b10, 1, -1, 5, -1, 1'b0, 1'b0);
    endtask

    task automatic test_wave_negmax();
        run_move("wave", 2'b00, -2, 3, 6, -1, 1'b1, 1'b0);
        run_move("negmax", 2'b11, -32768, 5, 4, 10, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_move("b2b_a", 2'b01, 2, -1, 4, -1, 1'b1, 1'b0);
        run_move("b2b_b", 2'b10, -3, 2, 4, -1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk_100mhz);
        hold_en    = 1'b1;
        cmd_mode   = 2'b10;
        cmd_period = PW'(4);
        cmd_steps  = {SW'(100), SW'(100)};
        cmd_valid  = 1'b1;
        @(posedge clk_100mhz);
        #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk_100mhz);
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid running: got %b want 1", busy); end
        do_reset();
        total++;
        if (coil_out !== 8'h88) begin bad++; $display("FAIL reset_mid coil: got %h want 88", coil_out); end
        total++;
        if (pos_out !== 40'h0) begin bad++; $display("FAIL reset_mid pos: got %h want 0", pos_out); end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid flags: got busy=%b done=%b ready=%b want 0 0 1", busy, done,
                     cmd_ready);
        end
        release_reset();
        run_move("after_reset", 2'b10, 1, 0, 4, -1, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        cpu_resetn = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_mode   = 2'b00;
        cmd_period = '0;
        abort      = 1'b0;
        hold_en    = 1'b0;
        test_reset();
        test_half();
        test_full_clamp();
        test_zero();
        test_abort();
        test_hold_resume();
        test_wave_negmax();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_move_ctrl.md
STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 Parameter NUM_AXES, default 2, number of independent 4-coil stepper axes.
REQ-002 Parameter STEP_W, default 16, width of per-axis signed step count.
REQ-003 Parameter PERIOD_W, default 24, width of step-period field.
REQ-004 Parameter MIN_PERIOD, default 100000, minimum clocks per step (1 ms at 100 MHz).
REQ-005 Parameter POS_W, default 20, width of per-axis signed position counter in half-step units.
REQ-006 clk_100mhz  in  1  sole clock; all logic on rising edge.
REQ-007 cpu_resetn  in  1  reset, synchronous, active-low.
REQ-008 cmd_valid  in  1  move command present.
REQ-009 cmd_ready  out  1  block accepts command this cycle.
REQ-010 cmd_steps  in  NUM_AXES*STEP_W  two's-complement step count per axis, axis 0 in LSBs; sign = direction.
REQ-011 cmd_mode  in  2  00 wave, 01 full, 10 half, 11 treated as full.
REQ-012 cmd_period  in  PERIOD_W  clocks per step.
REQ-013 abort  in  1  terminate current move.
REQ-014 hold_en  in  1  keep coils energised while idle.
REQ-015 coil_out  out  NUM_AXES*4  coil drive, axis 0 in bits [3:0].
REQ-016 pos_out  out  NUM_AXES*POS_W  signed accumulated position per axis.
REQ-017 busy  out  1  move in progress.
REQ-018 done  out  1  one-cycle move-complete pulse.

Function
REQ-019 States IDLE and RUN; cmd_ready = (state==IDLE); busy = (state==RUN).
REQ-020 Accept on cmd_valid & cmd_ready; latch mode, per-axis magnitude and direction, and period = max(cmd_period, MIN_PERIOD); state RUN next cycle.
REQ-021 Magnitude held in STEP_W-bit unsigned; most-negative value yields 2^(STEP_W-1) steps.
REQ-022 Half-step table index 0..7: 1000,1100,0100,0110,0010,0011,0001,1001 (coil bits [3:0] as written MSB-first).
REQ-023 On accept: wave mode clears phase index bit0, full mode sets bit0, half unchanged; coil_out reflects adjusted index next cycle.
REQ-024 Step tick counter counts 0..period-1 in RUN; tick asserts at period-1 and wraps to 0; first tick period cycles after accept.
REQ-025 On tick, every axis with remaining>0 advances: index +/-1 (half) or +/-2 (wave/full) modulo 8, remaining decrements, position +/-1 (half) or +/-2 (wave/full); positive count increments.
REQ-026 Axes with remaining==0 hold phase and position; axes finish independently, no interpolation.
REQ-027 When all remaining==0 in RUN (after a tick or at entry for zero-step command), next cycle: state IDLE, done=1 for that one cycle.
REQ-028 Zero-step command on all axes: done pulses 2 cycles after accept, no coil change other than REQ-023.
REQ-029 abort=1 in RUN: no further steps, state IDLE and done=1 next cycle; positions retained; abort in IDLE ignored; abort takes priority over a coincident tick.
REQ-030 cmd_valid while busy ignored; no queuing.
REQ-031 Position wraps modulo 2^POS_W.
REQ-032 In IDLE with hold_en=0, coil_out = 0 but phase index retained; in RUN coils always driven.

Reset
REQ-033 cpu_resetn=0 at any edge, including mid-move: state IDLE, phase indices 0, positions 0, remaining 0, tick counter 0, done 0, busy 0, cmd_ready 1 next cycle, coil_out 0 if hold_en=0 else 1000 per axis.

Structure
REQ-034 Package plotter_pkg holds mode enum, state enum, half-step table constant.
REQ-035 One sub-module stepper_phase_seq per axis (generate loop): phase index, remaining counter, position, coil lookup; top holds FSM and tick counter.

Verification (NUM_AXES=2, MIN_PERIOD=4)
REQ-036 Half mode, steps {+3,-2}, period 4 -> axis0 coils 1100,0100,0110 at cycles 4,8,12 after accept; axis1 1001,0001; pos {3,-2}; done at cycle 13.
REQ-037 Full mode, steps {+1,0}, period 2 (clamped to 4) from index 0 -> axis0 1100 after accept, 0110 at cycle 4; pos {2,0}.
REQ-038 Steps {0,0} -> done 2 cycles after accept, busy 1 cycle, positions unchanged.
REQ-039 Steps {+100,+100}, abort at cycle 10 -> exactly 2 steps, done at cycle 11, cmd_ready 1 at 11.
REQ-040 hold_en=0 after move -> coil_out 0 in IDLE; next +1 half step resumes from retained index; reset mid-move -> all outputs per REQ-033.
